// File: rtl/instr_encoder_writer.sv
// RV32I instruction encoder feeding a small FIFO that streams encoded words
// to instruction memory at an auto-incrementing, word-aligned address.
module instr_encoder_writer #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_id,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_val,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       count,
  output logic              illegal,
  output logic [5:0]        illegal_id
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [5:0]
    ID_LUI = 6'd0, ID_AUIPC = 6'd1, ID_JAL = 6'd2, ID_JALR = 6'd3,
    ID_BEQ = 6'd4, ID_BNE = 6'd5, ID_BLT = 6'd6, ID_BGE = 6'd7, ID_BLTU = 6'd8, ID_BGEU = 6'd9,
    ID_LB = 6'd10, ID_LH = 6'd11, ID_LW = 6'd12, ID_LBU = 6'd13, ID_LHU = 6'd14,
    ID_SB = 6'd15, ID_SH = 6'd16, ID_SW = 6'd17,
    ID_ADDI = 6'd18, ID_SLTI = 6'd19, ID_SLTIU = 6'd20, ID_XORI = 6'd21, ID_ORI = 6'd22,
    ID_ANDI = 6'd23, ID_SLLI = 6'd24, ID_SRLI = 6'd25, ID_SRAI = 6'd26,
    ID_ADD = 6'd27, ID_SUB = 6'd28, ID_SLL = 6'd29, ID_SLT = 6'd30, ID_SLTU = 6'd31,
    ID_XOR = 6'd32, ID_SRL = 6'd33, ID_SRA = 6'd34, ID_OR = 6'd35, ID_AND = 6'd36,
    ID_FENCE = 6'd37, ID_ECALL = 6'd38, ID_EBREAK = 6'd39,
    ID_CSRRW = 6'd40, ID_CSRRS = 6'd41, ID_CSRRC = 6'd42,
    ID_CSRRWI = 6'd43, ID_CSRRSI = 6'd44, ID_CSRRCI = 6'd45;

  localparam logic [6:0]
    OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
    OPC_BR = 7'b1100011, OPC_LD = 7'b0000011, OPC_ST = 7'b0100011, OPC_OPI = 7'b0010011,
    OPC_OP = 7'b0110011, OPC_FENCE = 7'b0001111, OPC_SYS = 7'b1110011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS} fmt_e;

  fmt_e        fmt_s;
  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic        legal_s;
  logic        sys_brk_s;
  logic [31:0] enc_s;

  logic [31:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    occ_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [15:0]       count_r;
  logic              illegal_r;
  logic [5:0]        illegal_id_r;

  logic accept_s;
  logic push_s;
  logic pop_s;
  logic unused_s;

  // Bits the word formats never consume.
  assign unused_s = &{1'b0, in_imm[31:21], addr_val[1:0]};

  // Decode the symbolic id into opcode, funct fields and word format.
  always_comb begin
    opc_s = 7'd0; f3_s = 3'd0; f7_s = 7'd0; fmt_s = FMT_R; legal_s = 1'b1; sys_brk_s = 1'b0;
    case (in_id)
      ID_LUI:    begin opc_s = OPC_LUI;   fmt_s = FMT_U; end
      ID_AUIPC:  begin opc_s = OPC_AUIPC; fmt_s = FMT_U; end
      ID_JAL:    begin opc_s = OPC_JAL;   fmt_s = FMT_J; end
      ID_JALR:   begin opc_s = OPC_JALR;  fmt_s = FMT_I; end
      ID_BEQ:    begin opc_s = OPC_BR; fmt_s = FMT_B; f3_s = 3'b000; end
      ID_BNE:    begin opc_s = OPC_BR; fmt_s = FMT_B; f3_s = 3'b001; end
      ID_BLT:    begin opc_s = OPC_BR; fmt_s = FMT_B; f3_s = 3'b100; end
      ID_BGE:    begin opc_s = OPC_BR; fmt_s = FMT_B; f3_s = 3'b101; end
      ID_BLTU:   begin opc_s = OPC_BR; fmt_s = FMT_B; f3_s = 3'b110; end
      ID_BGEU:   begin opc_s = OPC_BR; fmt_s = FMT_B; f3_s = 3'b111; end
      ID_LB:     begin opc_s = OPC_LD; fmt_s = FMT_I; f3_s = 3'b000; end
      ID_LH:     begin opc_s = OPC_LD; fmt_s = FMT_I; f3_s = 3'b001; end
      ID_LW:     begin opc_s = OPC_LD; fmt_s = FMT_I; f3_s = 3'b010; end
      ID_LBU:    begin opc_s = OPC_LD; fmt_s = FMT_I; f3_s = 3'b100; end
      ID_LHU:    begin opc_s = OPC_LD; fmt_s = FMT_I; f3_s = 3'b101; end
      ID_SB:     begin opc_s = OPC_ST; fmt_s = FMT_S; f3_s = 3'b000; end
      ID_SH:     begin opc_s = OPC_ST; fmt_s = FMT_S; f3_s = 3'b001; end
      ID_SW:     begin opc_s = OPC_ST; fmt_s = FMT_S; f3_s = 3'b010; end
      ID_ADDI:   begin opc_s = OPC_OPI; fmt_s = FMT_I; f3_s = 3'b000; end
      ID_SLTI:   begin opc_s = OPC_OPI; fmt_s = FMT_I; f3_s = 3'b010; end
      ID_SLTIU:  begin opc_s = OPC_OPI; fmt_s = FMT_I; f3_s = 3'b011; end
      ID_XORI:   begin opc_s = OPC_OPI; fmt_s = FMT_I; f3_s = 3'b100; end
      ID_ORI:    begin opc_s = OPC_OPI; fmt_s = FMT_I; f3_s = 3'b110; end
      ID_ANDI:   begin opc_s = OPC_OPI; fmt_s = FMT_I; f3_s = 3'b111; end
      ID_SLLI:   begin opc_s = OPC_OPI; fmt_s = FMT_SH; f3_s = 3'b001; end
      ID_SRLI:   begin opc_s = OPC_OPI; fmt_s = FMT_SH; f3_s = 3'b101; end
      ID_SRAI:   begin opc_s = OPC_OPI; fmt_s = FMT_SH; f3_s = 3'b101; f7_s = F7_ALT; end
      ID_ADD:    begin opc_s = OPC_OP; f3_s = 3'b000; end
      ID_SUB:    begin opc_s = OPC_OP; f3_s = 3'b000; f7_s = F7_ALT; end
      ID_SLL:    begin opc_s = OPC_OP; f3_s = 3'b001; end
      ID_SLT:    begin opc_s = OPC_OP; f3_s = 3'b010; end
      ID_SLTU:   begin opc_s = OPC_OP; f3_s = 3'b011; end
      ID_XOR:    begin opc_s = OPC_OP; f3_s = 3'b100; end
      ID_SRL:    begin opc_s = OPC_OP; f3_s = 3'b101; end
      ID_SRA:    begin opc_s = OPC_OP; f3_s = 3'b101; f7_s = F7_ALT; end
      ID_OR:     begin opc_s = OPC_OP; f3_s = 3'b110; end
      ID_AND:    begin opc_s = OPC_OP; f3_s = 3'b111; end
      ID_FENCE:  begin opc_s = OPC_FENCE; fmt_s = FMT_I; end
      ID_ECALL:  begin opc_s = OPC_SYS; fmt_s = FMT_SYS; end
      ID_EBREAK: begin opc_s = OPC_SYS; fmt_s = FMT_SYS; sys_brk_s = 1'b1; end
      ID_CSRRW:  begin opc_s = OPC_SYS; fmt_s = FMT_I; f3_s = 3'b001; end
      ID_CSRRS:  begin opc_s = OPC_SYS; fmt_s = FMT_I; f3_s = 3'b010; end
      ID_CSRRC:  begin opc_s = OPC_SYS; fmt_s = FMT_I; f3_s = 3'b011; end
      ID_CSRRWI: begin opc_s = OPC_SYS; fmt_s = FMT_I; f3_s = 3'b101; end
      ID_CSRRSI: begin opc_s = OPC_SYS; fmt_s = FMT_I; f3_s = 3'b110; end
      ID_CSRRCI: begin opc_s = OPC_SYS; fmt_s = FMT_I; f3_s = 3'b111; end
      default:   begin legal_s = 1'b0; end
    endcase
  end

  // Assemble the machine word; fields a format does not use stay zero.
  always_comb begin
    enc_s = 32'd0;
    case (fmt_s)
      FMT_R:   enc_s = {f7_s, in_rs2, in_rs1, f3_s, in_rd, opc_s};
      FMT_I:   enc_s = {in_imm[11:0], in_rs1, f3_s, in_rd, opc_s};
      FMT_SH:  enc_s = {f7_s, in_imm[4:0], in_rs1, f3_s, in_rd, opc_s};
      FMT_S:   enc_s = {in_imm[11:5], in_rs2, in_rs1, f3_s, in_imm[4:0], opc_s};
      FMT_B:   enc_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3_s,
                        in_imm[4:1], in_imm[11], opc_s};
      FMT_U:   enc_s = {in_imm[19:0], in_rd, opc_s};
      FMT_J:   enc_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc_s};
      FMT_SYS: enc_s = {11'd0, sys_brk_s, 13'd0, opc_s};
      default: enc_s = 32'd0;
    endcase
  end

  assign in_ready   = (occ_r != FULL_OCC);
  assign wr_valid   = (occ_r != '0);
  assign wr_data    = mem_r[rd_ptr_r];
  assign wr_addr    = wr_addr_r;
  assign count      = count_r;
  assign illegal    = illegal_r;
  assign illegal_id = illegal_id_r;

  assign accept_s = in_valid && in_ready;
  assign push_s   = accept_s && legal_s;
  assign pop_s    = wr_valid && wr_ready;

  // FIFO, write address, completion counter and sticky illegal capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 32'd0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      occ_r        <= '0;
      wr_addr_r    <= BASE_ADDR;
      count_r      <= 16'd0;
      illegal_r    <= 1'b0;
      illegal_id_r <= 6'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= enc_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        count_r  <= count_r + 16'd1;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + (PTR_W+1)'(1);
        2'b01:   occ_r <= occ_r - (PTR_W+1)'(1);
        default: occ_r <= occ_r;
      endcase
      // A load wins over the increment; the completing write already used the old address.
      if (addr_load) begin
        wr_addr_r <= {addr_val[ADDR_W-1:2], 2'b00};
      end else if (pop_s) begin
        wr_addr_r <= wr_addr_r + ADDR_W'(4);
      end
      if (accept_s && !legal_s && !illegal_r) begin
        illegal_r    <= 1'b1;
        illegal_id_r <= in_id;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Self-checking bench for instr_encoder_writer: directed scenarios plus random
// traffic compared every cycle against a queue-based behavioural model.
module tb_instr_encoder_writer;

  localparam int FD = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int BR_F3  [6]  = '{0, 1, 4, 5, 6, 7};
  localparam int LD_F3  [5]  = '{0, 1, 2, 4, 5};
  localparam int OPI_F3 [6]  = '{0, 2, 3, 4, 6, 7};
  localparam int OP_F3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  localparam int CSR_F3 [6]  = '{1, 2, 3, 5, 6, 7};

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [5:0]  in_id = 6'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [31:0] in_imm = 32'd0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_val = 32'd0;
  logic        wr_valid, wr_ready = 1'b0;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] count;
  logic        illegal;
  logic [5:0]  illegal_id;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_addr = BASE;
  logic [15:0] m_count = 16'd0;
  logic        m_ill = 1'b0;
  logic [5:0]  m_ill_id = 6'd0;
  bit          last_acc;

  always #5 clk = ~clk;

  instr_encoder_writer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_load(addr_load), .addr_val(addr_val), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .illegal(illegal),
    .illegal_id(illegal_id)
  );

  function automatic logic [31:0] i_word(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                         logic [31:0] rd, logic [31:0] op);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction

  // ISA encoding rules by instruction group, written with shifts and masks.
  function automatic logic [31:0] ref_encode(int id, logic [31:0] rd, logic [31:0] rs1,
                                             logic [31:0] rs2, logic [31:0] imm);
    if (id == 0) return ((imm & 32'hFFFFF) << 12) | (rd << 7) | 32'h37;
    if (id == 1) return ((imm & 32'hFFFFF) << 12) | (rd << 7) | 32'h17;
    if (id == 2) return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                        (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                        (rd << 7) | 32'h6F;
    if (id == 3) return i_word(imm, rs1, 32'd0, rd, 32'h67);
    if (id >= 4 && id <= 9)
      return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
             (rs1 << 15) | (32'(BR_F3[id-4]) << 12) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 32'h1) << 7) | 32'h63;
    if (id >= 10 && id <= 14) return i_word(imm, rs1, 32'(LD_F3[id-10]), rd, 32'h03);
    if (id >= 15 && id <= 17)
      return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) |
             (32'(id - 15) << 12) | ((imm & 32'h1F) << 7) | 32'h23;
    if (id >= 18 && id <= 23) return i_word(imm, rs1, 32'(OPI_F3[id-18]), rd, 32'h13);
    if (id >= 24 && id <= 26)
      return i_word((imm & 32'h1F) | ((id == 26) ? 32'h400 : 32'h0), rs1,
                    (id == 24) ? 32'd1 : 32'd5, rd, 32'h13);
    if (id >= 27 && id <= 36)
      return (((id == 28 || id == 34) ? 32'h20 : 32'h0) << 25) | (rs2 << 20) | (rs1 << 15) |
             (32'(OP_F3[id-27]) << 12) | (rd << 7) | 32'h33;
    if (id == 37) return i_word(imm, rs1, 32'd0, rd, 32'h0F);
    if (id == 38) return 32'h0000_0073;
    if (id == 39) return 32'h0010_0073;
    if (id >= 40 && id <= 45) return i_word(imm, rs1, 32'(CSR_F3[id-40]), rd, 32'h73);
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_addr = BASE; m_count = 16'd0; m_ill = 1'b0; m_ill_id = 6'd0;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 after the rise.
  task automatic cycle();
    bit pop;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < FD));
    chk("wr_valid", 32'(wr_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, exp_q[0]);
    end
    chk("count", 32'(count), 32'(m_count));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("illegal_id", 32'(illegal_id), 32'(m_ill_id));
    last_acc = in_valid && (exp_q.size() < FD);
    pop = (exp_q.size() != 0) && wr_ready;
    if (pop) begin
      void'(exp_q.pop_front());
      m_count = m_count + 16'd1;
    end
    if (addr_load) m_addr = addr_val & ~32'h3;
    else if (pop) m_addr = m_addr + 32'd4;
    if (last_acc) begin
      if (in_id <= 6'd45)
        exp_q.push_back(ref_encode(int'(in_id), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm));
      else if (!m_ill) begin
        m_ill = 1'b1; m_ill_id = in_id;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [5:0] id, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    in_id = id; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) cycle();
    chk("req_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; addr_load = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
  endtask

  task automatic push_and_see(input string tag, input logic [5:0] id, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [31:0] word);
    drain();
    wr_ready = 1'b0;
    req(id, rd, rs1, rs2, imm);
    chk(tag, wr_data, word);
    chk({tag, "_valid"}, 32'(wr_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, BASE);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_illegal_id"}, 32'(illegal_id), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();
    cycle();

    // First word: latency, base address, counter.
    push_and_see("addi_word", 6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    chk("addi_addr", wr_addr, 32'h8000_0000);
    wr_ready = 1'b1;
    cycle();
    chk("count_after_first", 32'(count), 32'd1);

    push_and_see("sw_word",  6'd17, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423);
    push_and_see("jal_word", 6'd2,  5'd1, 5'd0, 5'd0, 32'd16, 32'h0100_00EF);
    push_and_see("beq_word", 6'd4,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3);

    // Back-pressure: two accepts fill the buffer, the third waits.
    drain();
    wr_ready = 1'b0;
    req(6'd18, 5'd3, 5'd4, 5'd0, 32'd7);
    req(6'd27, 5'd5, 5'd6, 5'd7, 32'd0);
    in_id = 6'd28; in_rd = 5'd8; in_rs1 = 5'd9; in_rs2 = 5'd10; in_valid = 1'b1;
    repeat (3) cycle();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    wr_ready = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) cycle();
    chk("stall_third_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;

    push_and_see("ecall_word",  6'd38, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0073);
    push_and_see("ebreak_word", 6'd39, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0010_0073);
    push_and_see("lui_word",    6'd0,  5'd5, 5'd0, 5'd0, 32'h0001_2345, 32'h1234_52B7);

    // Illegal id is consumed, reported and never written.
    drain();
    req(6'd63, 5'd1, 5'd2, 5'd3, 32'd0);
    chk("illegal_flag", 32'(illegal), 32'd1);
    chk("illegal_id_cap", 32'(illegal_id), 32'd63);
    chk("illegal_no_write", 32'(wr_valid), 32'd0);
    push_and_see("after_illegal", 6'd18, 5'd2, 5'd2, 5'd0, 32'd1, 32'h0011_0113);

    // Address load coinciding with a completing write.
    drain();
    wr_ready = 1'b0;
    req(6'd18, 5'd1, 5'd1, 5'd0, 32'd1);
    req(6'd18, 5'd2, 5'd2, 5'd0, 32'd2);
    wr_ready = 1'b1; addr_load = 1'b1; addr_val = 32'h0000_1006;
    cycle();
    addr_load = 1'b0;
    chk("addr_load_next", wr_addr, 32'h0000_1004);
    drain();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      in_id     = (($urandom % 8) == 0) ? 6'($urandom_range(46, 63)) : 6'($urandom_range(0, 45));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_imm    = $urandom;
      wr_ready  = ($urandom % 3) != 0;
      addr_load = ($urandom % 16) == 0;
      addr_val  = $urandom;
      cycle();
    end
    drain();

    // Asynchronous reset with words pending.
    wr_ready = 1'b0;
    req(6'd18, 5'd1, 5'd0, 5'd0, 32'd9);
    req(6'd18, 5'd2, 5'd0, 5'd0, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    push_and_see("post_reset", 6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    chk("post_reset_addr", wr_addr, BASE);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
